// File: rtl/param_counter.sv
// param_counter
//
// Purpose:
//   Modulo-MODULUS up/down counter with a clock prescaler, wrap or saturate
//   behaviour at the limits, synchronous clear and load, and registered
//   step (tick) and terminal-count (tc) pulses.
//
// Parameters:
//   WIDTH     width of count_o and load_val_i
//   MODULUS   number of count states, count_o runs 0..MODULUS-1
//   PRESCALE  clk cycles (while enabled) per count step
//
// Ports:
//   clk         input   1      rising-edge clock
//   rst         input   1      asynchronous active-low reset
//   en_i        input   1      enables the prescaler and counting
//   up_i        input   1      1 = count up, 0 = count down
//   sat_i       input   1      0 = wrap at the limits, 1 = saturate
//   clr_i       input   1      synchronous clear (highest priority)
//   load_i      input   1      synchronous load of load_val_i
//   load_val_i  input   WIDTH  value to load, clamped to MODULUS-1
//   count_o     output  WIDTH  registered count
//   tick_o      output  1      one-cycle pulse after each count step
//   tc_o        output  1      one-cycle pulse after a step taken from the limit
module param_counter #(
  parameter int WIDTH    = 6,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             sat_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic             tc_o
);

  // Illegal parameter combinations stop elaboration outright.
  if (MODULUS < 2) begin : g_badModulusLow
    $fatal(1, "param_counter: MODULUS must be at least 2");
  end
  if (MODULUS > (2 ** WIDTH)) begin : g_badModulusHigh
    $fatal(1, "param_counter: MODULUS must not exceed 2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_badPrescale
    $fatal(1, "param_counter: PRESCALE must be at least 1");
  end

  localparam int PW = $clog2(PRESCALE) + 1;

  localparam logic [WIDTH-1:0] CMAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CZERO = '0;
  localparam logic [WIDTH-1:0] CONE  = WIDTH'(1);
  localparam logic [PW-1:0]    PMAX  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PONE  = PW'(1);

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre;
  logic             r_tick;
  logic             r_tc;

  logic             w_step;
  logic             w_atLimit;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_loadClamped;

  assign w_step = en_i && (r_pre == PMAX);

  // The limit depends on direction: top of range going up, zero going down.
  assign w_atLimit = up_i ? (r_count == CMAX) : (r_count == CZERO);

  // Next count on a step; never leaves 0..MODULUS-1 because the limit case
  // is handled explicitly instead of relying on binary overflow.
  always_comb begin
    w_next = r_count;
    if (up_i) begin
      if (w_atLimit) w_next = sat_i ? CMAX : CZERO;
      else           w_next = r_count + CONE;
    end else begin
      if (w_atLimit) w_next = sat_i ? CZERO : CMAX;
      else           w_next = r_count - CONE;
    end
  end

  assign w_loadClamped = (load_val_i > CMAX) ? CMAX : load_val_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (clr_i) begin
      r_count <= '0;
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else if (load_i) begin
      r_count <= w_loadClamped;
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      r_tick <= w_step;
      r_tc   <= w_step && w_atLimit;
      // Prescaler phase is frozen while disabled so a pause simply delays the step.
      if (en_i) begin
        r_pre <= w_step ? '0 : (r_pre + PONE);
      end
      if (w_step) begin
        r_count <= w_next;
      end
    end
  end

  assign count_o = r_count;
  assign tick_o  = r_tick;
  assign tc_o    = r_tc;

endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter
//
// Directed bench for param_counter. One instance uses the default parameters
// (WIDTH 6, MODULUS 10, PRESCALE 1); a second instance uses PRESCALE 4 to
// exercise the prescaler. Inputs change 1 time unit after each rising edge and
// outputs are sampled at that same point, away from the active edge.
module tb_param_counter;

  logic       clk;
  logic       rst;
  logic       enI;
  logic       upI;
  logic       satI;
  logic       clrI;
  logic       loadI;
  logic [5:0] loadValI;
  logic [5:0] countO;
  logic       tickO;
  logic       tcO;

  logic       psEn;
  logic       psUp;
  logic       psSat;
  logic       psClr;
  logic       psLoad;
  logic [5:0] psLoadVal;
  logic [5:0] psCount;
  logic       psTick;
  logic       psTc;

  int checks;
  int errors;

  param_counter dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (enI),
    .up_i       (upI),
    .sat_i      (satI),
    .clr_i      (clrI),
    .load_i     (loadI),
    .load_val_i (loadValI),
    .count_o    (countO),
    .tick_o     (tickO),
    .tc_o       (tcO)
  );

  param_counter #(.WIDTH(6), .MODULUS(10), .PRESCALE(4)) dutPs (
    .clk        (clk),
    .rst        (rst),
    .en_i       (psEn),
    .up_i       (psUp),
    .sat_i      (psSat),
    .clr_i      (psClr),
    .load_i     (psLoad),
    .load_val_i (psLoadVal),
    .count_o    (psCount),
    .tick_o     (psTick),
    .tc_o       (psTc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives the default instance's inputs, then advances one rising edge and
  // settles 1 time unit past it.
  task automatic applyStimulus(input logic en, input logic up, input logic sat,
                               input logic clr, input logic load, input logic [5:0] val);
    enI      = en;
    upI      = up;
    satI     = sat;
    clrI     = clr;
    loadI    = load;
    loadValI = val;
    @(posedge clk);
    #1;
  endtask

  // Checks count, tick and tc of the default instance in one call.
  task automatic checkMain(input string tag, input int expCount, input int expTick, input int expTc);
    checkOutput({tag, ".count"}, int'(countO), expCount);
    checkOutput({tag, ".tick"}, int'(tickO), expTick);
    checkOutput({tag, ".tc"}, int'(tcO), expTc);
  endtask

  // Expected vectors for the PRESCALE=4 instance, one entry per edge.
  int psEnTab[16]    = '{1,1,1,1, 1,1,1,1, 1,1,0,0, 0,1,1,1};
  int psUpTab[16]    = '{1,1,1,1, 1,1,1,1, 1,1,1,0, 1,1,1,1};
  int psTickTab[16]  = '{0,0,0,1, 0,0,0,1, 0,0,0,0, 0,0,1,0};
  int psCountTab[16] = '{0,0,0,1, 1,1,1,2, 2,2,2,2, 2,2,3,3};

  // Down/saturate sequence after loading 2.
  int downCountTab[4] = '{1,0,0,0};
  int downTcTab[4]    = '{0,0,1,1};

  // Main directed sequence.
  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    enI       = 1'b1;
    upI       = 1'b1;
    satI      = 1'b0;
    clrI      = 1'b0;
    loadI     = 1'b0;
    loadValI  = '0;
    psEn      = 1'b0;
    psUp      = 1'b1;
    psSat     = 1'b0;
    psClr     = 1'b0;
    psLoad    = 1'b0;
    psLoadVal = '0;

    #2;
    checkMain("reset", 0, 0, 0);
    checkOutput("reset.psCount", int'(psCount), 0);
    checkOutput("reset.psTick", int'(psTick), 0);

    @(negedge clk);
    rst = 1'b1;

    $display("[TB] wrap-up count with PRESCALE 1");
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
      checkMain($sformatf("wrapUp%0d", k), k % 10, 1, (k == 10) ? 1 : 0);
    end
    for (int k = 3; k <= 7; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
      checkOutput($sformatf("toSeven%0d.count", k), int'(countO), k);
    end

    $display("[TB] asynchronous reset mid-count");
    #3;
    rst = 1'b0;
    #1;
    checkMain("asyncRst", 0, 0, 0);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    checkMain("afterRst", 1, 1, 0);

    $display("[TB] down count with saturation");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd2);
    checkMain("load2", 2, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
      checkMain($sformatf("downSat%0d", k), downCountTab[k], 1, downTcTab[k]);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkMain("downWrap", 9, 1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    checkMain("downPast", 8, 1, 0);

    $display("[TB] load clamp, clear priority, saturate up");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd15);
    checkMain("load15", 9, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    checkMain("upSat", 9, 1, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    checkMain("upWrap", 0, 1, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    checkMain("upOne", 1, 1, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd5);
    checkMain("clrLoad", 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    checkMain("afterClr", 1, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5);
    checkMain("loadNoEn", 5, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
    checkMain("holdNoEn", 5, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
    checkMain("clrNoEn", 0, 0, 0);

    $display("[TB] prescaler of 4 with a 3-cycle pause");
    enI = 1'b0;
    for (int e = 0; e < 16; e++) begin
      psEn = psEnTab[e][0];
      psUp = psUpTab[e][0];
      @(posedge clk);
      #1;
      checkOutput($sformatf("ps%0d.tick", e + 1), int'(psTick), psTickTab[e]);
      checkOutput($sformatf("ps%0d.count", e + 1), int'(psCount), psCountTab[e]);
      checkOutput($sformatf("ps%0d.tc", e + 1), int'(psTc), 0);
    end
    checkOutput("psMainIdle.count", int'(countO), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 6, width of count_o and load_val_i.
REQ-002 SHALL have parameter MODULUS, default 10, number of count states (0..MODULUS-1).
REQ-003 SHALL have parameter PRESCALE, default 1, clk cycles per count step.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en_i  input  1  enables the prescaler and counting.
REQ-007 SHALL have port up_i  input  1  direction: 1 = up, 0 = down.
REQ-008 SHALL have port sat_i  input  1  mode: 0 = wrap, 1 = saturate at the limits.
REQ-009 SHALL have port clr_i  input  1  synchronous clear.
REQ-010 SHALL have port load_i  input  1  synchronous load of load_val_i.
REQ-011 SHALL have port load_val_i  input  WIDTH  value to load.
REQ-012 SHALL have port count_o  output  WIDTH  registered count value.
REQ-013 SHALL have port tick_o  output  1  registered; one-cycle pulse on each count step.
REQ-014 SHALL have port tc_o  output  1  registered; one-cycle terminal-count pulse.

Function
REQ-015 SHALL require MODULUS >= 2, MODULUS <= 2**WIDTH and PRESCALE >= 1; violations SHALL be a fatal elaboration error.
REQ-016 SHALL hold an internal prescaler of width clog2(PRESCALE)+1; the prescaler advances only while en_i=1 and is held while en_i=0.
REQ-017 SHALL generate a step on the edge where the prescaler equals PRESCALE-1 with en_i=1, and SHALL return the prescaler to 0 on that edge. With PRESCALE=1, every enabled cycle SHALL be a step.
REQ-018 SHALL apply priority clr_i > load_i > step on each edge.
REQ-019 clr_i=1 SHALL set count_o=0 and prescaler=0, and SHALL force tick_o=0 and tc_o=0 next cycle, regardless of en_i.
REQ-020 load_i=1 (clr_i=0) SHALL set count_o=min(load_val_i, MODULUS-1) and prescaler=0, and SHALL force tick_o=0 and tc_o=0, regardless of en_i.
REQ-021 On a step in up mode, count_o SHALL increment by 1 below MODULUS-1. At MODULUS-1 it SHALL become 0 in wrap mode and hold at MODULUS-1 in saturate mode.
REQ-022 On a step in down mode, count_o SHALL decrement by 1 above 0. At 0 it SHALL become MODULUS-1 in wrap mode and hold at 0 in saturate mode.
REQ-023 tick_o SHALL be 1 exactly in the cycle following each step edge, coincident with the updated count_o.
REQ-024 tc_o SHALL be 1 in the cycle following a step taken from the limit in the current direction (MODULUS-1 up, 0 down), in both wrap and saturate modes; otherwise 0.
REQ-025 up_i and sat_i SHALL be sampled at the step edge; changing them between steps SHALL NOT disturb the prescaler.
REQ-026 Arithmetic SHALL never produce a count_o value >= MODULUS, including for non-power-of-two MODULUS.

Reset
REQ-027 While rst=0, count_o=0, tick_o=0, tc_o=0 and prescaler=0 SHALL hold immediately, independent of clk.
REQ-028 Deassertion of rst SHALL be honoured at the next rising edge of clk. The first step SHALL occur PRESCALE enabled cycles after deassertion.
REQ-029 Asserting rst mid-count SHALL discard the prescaler phase and any pending tick_o/tc_o.

Verification
REQ-030 Defaults, en_i=1, up_i=1, sat_i=0, 12 cycles after reset -> count_o 0,1,...,9,0,1; tc_o=1 only with the first 0 after 9; tick_o=1 every cycle.
REQ-031 PRESCALE=4, up, en_i=1 -> count_o changes every 4th cycle; tick_o=1 for 1 cycle in 4; en_i=0 for 3 cycles mid-phase -> step delayed by exactly 3 cycles.
REQ-032 Down mode, sat_i=1, load 2 -> count_o 2,1,0,0,0; tc_o=1 on each step attempted at 0. Switch to sat_i=0 -> next step gives count_o=9 with tc_o=1.
REQ-033 load_val_i=15 with load_i=1 -> count_o=9. clr_i and load_i together -> count_o=0. load_i with en_i=0 -> count_o loads and no tick_o.
REQ-034 rst pulled low asynchronously between edges at count_o=7 -> all outputs 0 before the next edge; release -> counting restarts from 0.
